rr_hold_arbiter: RTL

- Parametrised round-robin arbiter with grant locking, for shared cache/memory-bus ports.
- The winner keeps the grant across a multi-cycle transaction until it releases, drops its request, or exceeds an optional hold limit.
- It then re-arbitrates back-to-back with no bubble when other requesters are pending.
- Fixed-priority mode is selectable for debug and regression comparison.

---
 rtl/rr_hold_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant locking for shared cache/memory-bus ports.
// The winner keeps the grant until it releases, drops its request, or hits
// the optional hold limit. Other pending requesters are then re-arbitrated
// back-to-back with no bubble. MODE="FIXED" gives lowest-index-wins
// priority for debug. The owner-finished input is named release_in because
// "release" is a reserved word in the language.
module rr_hold_arbiter #(
   parameter int    WIDTH      = 4,
   parameter string MODE       = "RR",
   parameter int    HOLD_LIMIT = 0,
   localparam int   GW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] requests,
   input  logic             release_in,
   output logic             grant_valid,
   output logic [GW-1:0]    grant,
   output logic [WIDTH-1:0] grant_onehot,
   output logic             preempt
);

   localparam bit          FIXED_MODE = (MODE == "FIXED");
   // The hold counter saturates at the limit, or at all-ones when unlimited.
   localparam logic [15:0] HOLD_MAX   = (HOLD_LIMIT == 0) ? 16'hFFFF : 16'(HOLD_LIMIT);

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [WIDTH-1:0] onehot_q, onehot_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [15:0]      hold_q, hold_d;
   logic             preempt_q, preempt_d;

   logic             owner_req;
   logic             limit_hit;
   logic             tenure_end;
   logic [WIDTH-1:0] elig;
   logic [WIDTH-1:0] masked;
   logic [WIDTH-1:0] pick;
   logic [GW-1:0]    winner;

   // Detect end of tenure and build the vector of requesters eligible to win.
   always_comb begin
      owner_req  = requests[grant_q];
      limit_hit  = (HOLD_LIMIT != 0) && (hold_q == HOLD_MAX);
      tenure_end = (state_q == GRANTED) && (release_in || !owner_req || limit_hit);
      elig       = '0;
      if (state_q == IDLE) begin
         elig = requests;
      end else if (tenure_end) begin
         elig = requests & ~onehot_q;
      end
   end

   // Pick the lowest eligible index above the pointer, wrapping to the lowest overall.
   always_comb begin
      masked = '0;
      for (int i = 0; i < WIDTH; i++) begin
         masked[i] = elig[i] && !FIXED_MODE && (i > int'(ptr_q));
      end
      pick   = (|masked) ? masked : elig;
      winner = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pick[i]) begin
            winner = GW'(i);
         end
      end
   end

   // Next-state logic: grant a new winner, fall back to IDLE, or keep holding.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      onehot_d  = onehot_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      preempt_d = tenure_end && limit_hit && !release_in && owner_req;
      if (|elig) begin
         state_d  = GRANTED;
         grant_d  = winner;
         onehot_d = WIDTH'(1) << winner;
         ptr_d    = winner;
         hold_d   = 16'd1;
      end else if (tenure_end) begin
         state_d  = IDLE;
         onehot_d = '0;
         hold_d   = '0;
      end else if ((state_q == GRANTED) && (hold_q != HOLD_MAX)) begin
         hold_d   = hold_q + 16'd1;
      end
   end

   // State and output registers with synchronous reset; the pointer starts at
   // WIDTH-1 so the first round-robin decision favours index 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         onehot_q  <= '0;
         ptr_q     <= GW'(WIDTH - 1);
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         onehot_q  <= onehot_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign grant_valid  = (state_q == GRANTED);
   assign grant        = grant_q;
   assign grant_onehot = onehot_q;
   assign preempt      = preempt_q;

endmodule
